// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    RUN,
    ERROR
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_WIDTH      = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream valid/ready channel feeding the instruction memory loader.
interface imem_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word packer: shifts bytes in MSB-first and flags the completing byte.
module imem_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);
  import mips_loader_pkg::*;

  logic [31:0] word_q;
  logic [1:0]  byte_cnt_q;

  // High on the shift that delivers the last byte of a word; the counter wraps to 0 with it.
  assign word_full = shift_en && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_out  = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else if (clear) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else if (shift_en) begin
      word_q     <= {word_q[23:0], byte_in};
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> sequential 32-bit instruction memory writes,
// holding the pipeline stalled until the whole program is in place.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_loader_if.slave          s,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  load_done,
  output logic                  error
);
  import mips_loader_pkg::*;

  localparam logic [LEN_WIDTH:0] DEPTH = (LEN_WIDTH + 1)'(2 ** ADDR_WIDTH);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  len_full;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [31:0]           wdata_hold_q;
  logic [31:0]           word;
  logic                  load_done_q;
  logic                  xfer, shift_en, asm_clear, word_full, last_word;

  assign s.s_ready = rst_n && (state_q == LEN_HI || state_q == LEN_LO || state_q == DATA);
  assign xfer      = s.s_valid && s.s_ready;
  assign len_full  = {len_q[LEN_WIDTH-1:8], s.s_data};
  assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

  imem_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .clear     (asm_clear),
    .byte_in   (s.s_data),
    .word_out  (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    shift_en   = 1'b0;
    asm_clear  = 1'b0;
    unique case (state_q)
      LEN_HI: begin
        if (xfer) begin
          len_d[LEN_WIDTH-1:8] = s.s_data;
          state_d              = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == '0)                   state_d = RUN;
          else if ({1'b0, len_full} > DEPTH)    state_d = ERROR;
          else                                  state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          shift_en = 1'b1;
          if (word_full) state_d = WRITE;
        end
      end
      WRITE: begin
        // Counter stops on the last word so a full-depth load never wraps back to 0.
        if (last_word) begin
          state_d = RUN;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = DATA;
        end
      end
      RUN, ERROR: begin
        if (restart) begin
          state_d    = LEN_HI;
          word_cnt_d = '0;
          asm_clear  = 1'b1;
        end
      end
      default: state_d = LEN_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LEN_HI;
      len_q        <= '0;
      word_cnt_q   <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      load_done_q <= (state_d == RUN) && (state_q != RUN);
      if (state_q == WRITE) begin
        addr_hold_q  <= word_cnt_q;
        wdata_hold_q <= word;
      end
    end
  end

  // Address/data are live during WRITE and otherwise keep the last written values.
  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = imem_we ? word_cnt_q : addr_hold_q;
  assign imem_wdata = imem_we ? word : wdata_hold_q;
  assign cpu_run    = (state_q == RUN);
  assign error      = (state_q == ERROR);
  assign load_done  = load_done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stream framing, write sequencing, run/error control.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run, load_done, error;

  int checks = 0;
  int failures = 0;

  logic [7:0]  wa[$];
  logic [31:0] wd[$];
  int          ready_in_write = 0;

  imem_loader_if bus ();

  imem_loader #(.ADDR_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (bus),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen at the sampling edge.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      if (bus.s_ready) ready_in_write++;
    end
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (!bus.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout: s_ready=%b required 1 within 20 cycles", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready: got %b required 0", bus.s_ready); end
    checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL rst_cpu_run: got %b required 0", cpu_run); end
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL rst_imem_we: got %b required 0", imem_we); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error: got %b required 0", error); end
    checks++; if ({imem_addr, imem_wdata} !== 40'h0) begin failures++; $display("FAIL rst_addr_data: got %h required 0", {imem_addr, imem_wdata}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL rst_release_s_ready: got %b required 1", bus.s_ready); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rst_load_done: got %b required 0", load_done); end
  endtask

  task automatic test_basic_load();
    int base = wa.size();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'hDEADBEEF, 0);
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h00, 32'hDEADBEEF}) begin failures++; $display("FAIL basic_write0: got we=%b addr=%h data=%h required 1/00/deadbeef", imem_we, imem_addr, imem_wdata); end
    send_word(32'h01234567, 0);
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h01, 32'h01234567}) begin failures++; $display("FAIL basic_write1: got we=%b addr=%h data=%h required 1/01/01234567", imem_we, imem_addr, imem_wdata); end
    checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL basic_run_early: got %b required 0", cpu_run); end
    @(negedge clk);
    checks++; if ({cpu_run, load_done, imem_we} !== 3'b110) begin failures++; $display("FAIL basic_run_entry: got run/done/we=%b required 110", {cpu_run, load_done, imem_we}); end
    checks++; if ({imem_addr, imem_wdata} !== {8'h01, 32'h01234567}) begin failures++; $display("FAIL basic_hold: got %h required 0101234567", {imem_addr, imem_wdata}); end
    @(negedge clk);
    checks++; if ({cpu_run, load_done} !== 2'b10) begin failures++; $display("FAIL basic_done_pulse: got run/done=%b required 10", {cpu_run, load_done}); end
    checks++; if (wa.size() - base !== 2) begin failures++; $display("FAIL basic_write_count: got %0d required 2", wa.size() - base); end
  endtask

  task automatic test_back_to_back_gaps();
    int base = wa.size();
    int rdy0 = ready_in_write;
    pulse_restart();
    checks++; if ({cpu_run, bus.s_ready} !== 2'b01) begin failures++; $display("FAIL gap_restart: got run/ready=%b required 01", {cpu_run, bus.s_ready}); end
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_word(32'hDEADBEEF, 1);
    checks++; if ({imem_we, bus.s_ready} !== 2'b10) begin failures++; $display("FAIL gap_write_ready: got we/ready=%b required 10", {imem_we, bus.s_ready}); end
    send_word(32'h01234567, 1);
    @(negedge clk);
    checks++; if (wa.size() - base !== 2) begin failures++; $display("FAIL gap_write_count: got %0d required 2", wa.size() - base); end
    else begin
      checks++; if ({wa[base], wd[base], wa[base+1], wd[base+1]} !== {8'h00, 32'hDEADBEEF, 8'h01, 32'h01234567}) begin failures++; $display("FAIL gap_writes: got %h/%h %h/%h required 00/deadbeef 01/01234567", wa[base], wd[base], wa[base+1], wd[base+1]); end
    end
    checks++; if (ready_in_write !== rdy0) begin failures++; $display("FAIL gap_ready_in_write: got %0d required %0d", ready_in_write, rdy0); end
    checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL gap_run: got %b required 1", cpu_run); end
  endtask

  task automatic test_header_edges();
    int base;
    pulse_restart();
    base = wa.size();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++; if ({cpu_run, load_done, imem_we} !== 3'b110) begin failures++; $display("FAIL zero_len_run: got run/done/we=%b required 110", {cpu_run, load_done, imem_we}); end
    checks++; if (wa.size() !== base) begin failures++; $display("FAIL zero_len_writes: got %0d required %0d", wa.size(), base); end
    pulse_restart();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++; if ({error, bus.s_ready, cpu_run} !== 3'b100) begin failures++; $display("FAIL overlen_error: got err/ready/run=%b required 100", {error, bus.s_ready, cpu_run}); end
    @(negedge clk);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL overlen_hold: got %b required 1", error); end
    pulse_restart();
    checks++; if ({error, bus.s_ready, cpu_run} !== 3'b010) begin failures++; $display("FAIL overlen_restart: got err/ready/run=%b required 010", {error, bus.s_ready, cpu_run}); end
  endtask

  task automatic test_full_depth();
    int base = wa.size();
    int bad = 0;
    logic [7:0] k;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      k = 8'(i);
      send_word({k, ~k, 8'h5A, k}, 0);
    end
    checks++; if ({imem_addr, imem_wdata} !== {8'hFF, 32'hFF005AFF}) begin failures++; $display("FAIL depth_last: got %h required ff005aff at ff", {imem_addr, imem_wdata}); end
    @(negedge clk);
    checks++; if ({cpu_run, load_done} !== 2'b11) begin failures++; $display("FAIL depth_run: got run/done=%b required 11", {cpu_run, load_done}); end
    checks++; if (wa.size() - base !== 256) begin failures++; $display("FAIL depth_count: got %0d required 256", wa.size() - base); end
    else begin
      for (int i = 0; i < 256; i++) begin
        k = 8'(i);
        if (wa[base+i] !== k || wd[base+i] !== {k, ~k, 8'h5A, k}) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL depth_sequence: got %0d bad writes required 0", bad); end
    end
  endtask

  task automatic test_reset_mid_load();
    int base;
    pulse_restart();
    base = wa.size();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({bus.s_ready, imem_we, cpu_run} !== 3'b000) begin failures++; $display("FAIL midrst_outputs: got ready/we/run=%b required 000", {bus.s_ready, imem_we, cpu_run}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wa.size() !== base) begin failures++; $display("FAIL midrst_no_write: got %0d required %0d", wa.size(), base); end
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hCAFEBABE, 0);
    @(negedge clk);
    checks++; if (wa.size() - base !== 1) begin failures++; $display("FAIL midrst_count: got %0d required 1", wa.size() - base); end
    else begin
      checks++; if ({wa[base], wd[base]} !== {8'h00, 32'hCAFEBABE}) begin failures++; $display("FAIL midrst_write: got %h/%h required 00/cafebabe", wa[base], wd[base]); end
    end
    checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL midrst_run: got %b required 1", cpu_run); end
  endtask

  task automatic test_restart();
    int base;
    pulse_restart();
    base = wa.size();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_restart();
    checks++; if ({bus.s_ready, cpu_run} !== 2'b10) begin failures++; $display("FAIL restart_in_data: got ready/run=%b required 10", {bus.s_ready, cpu_run}); end
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h00, 32'h11223344}) begin failures++; $display("FAIL restart_ignored_write: got we=%b addr=%h data=%h required 1/00/11223344", imem_we, imem_addr, imem_wdata); end
    @(negedge clk);
    pulse_restart();
    checks++; if ({cpu_run, bus.s_ready} !== 2'b01) begin failures++; $display("FAIL restart_in_run: got run/ready=%b required 01", {cpu_run, bus.s_ready}); end
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h55667788, 0);
    checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h00, 32'h55667788}) begin failures++; $display("FAIL restart_reload: got we=%b addr=%h data=%h required 1/00/55667788", imem_we, imem_addr, imem_wdata); end
    @(negedge clk);
    checks++; if (wa.size() - base !== 2) begin failures++; $display("FAIL restart_count: got %0d required 2", wa.size() - base); end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    test_reset();
    test_basic_load();
    test_back_to_back_gaps();
    test_header_edges();
    test_full_depth();
    test_reset_mid_load();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
